single_pc_sequencer: RTL
========================

# single_pc_sequencer

Owns the program counter of the single-issue core and sequences instruction fetch. It holds the word-addressed PC and issues one request at a time to instruction memory over a req/ack handshake. Fetched words go to decode over a valid/ready handshake. Branch and jump redirects from execute are applied with a defined kill of any in-flight or undelivered fetch. It sits between the next-PC logic and the instruction memory port.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word address)
- TIMEOUT, 16, max cycles a request may wait for ack before o_imem_timeout sets
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- o_pc  out  32  word address of current fetch; drives instruction memory address
- o_imem_req  out  1  fetch request
- i_imem_ack  in  1  memory completes the request this cycle (may be same cycle as req)
- i_imem_data  in  32  instruction word, valid when i_imem_ack=1
- o_inst  out  32  registered instruction to decode
- o_inst_pc  out  32  PC of o_inst
- o_inst_valid  out  1  o_inst is valid
- i_inst_ready  in  1  decode accepts o_inst this cycle
- i_redirect  in  1  branch/jump taken
- i_redirect_pc  in  32  target word address
- o_imem_timeout  out  1  sticky: a request exceeded TIMEOUT cycles

## Operation
- States: BOOT, FETCH, DELIV.
- Reset, rst=1 at an edge, from any state mid-transaction: state=BOOT, pc=RESET_PC, o_imem_req=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, kill=0, wait counter=0, o_imem_timeout=0.
- BOOT: req=0; next state FETCH unconditionally.
- FETCH: req=1 and o_pc stable until ack. A transaction completes on a cycle with req&&ack.
  - Completion without kill: o_inst<=i_imem_data, o_inst_pc<=pc, go to DELIV.
  - Completion with kill: drop the data, pc<=pending target, clear kill, stay FETCH. A new request issues the next cycle.
- Redirect in FETCH with no ack that cycle: set kill, pending<=i_redirect_pc. The address does not change mid-request. A later redirect overwrites pending; the last one wins.
- Redirect in FETCH on the same cycle as ack: treat as completion with kill, using i_redirect_pc directly.
- DELIV: o_inst_valid=1, req=0; o_inst and o_inst_pc hold.
  - ready=1, no redirect: pc<=pc+1, go to FETCH.
  - ready=1 with redirect: the instruction is accepted, pc<=i_redirect_pc, go to FETCH.
  - redirect with ready=0: drop the instruction (valid falls next cycle), pc<=i_redirect_pc, go to FETCH.
  - ready=0, no redirect: hold.
- Increment is modulo 2^32: 32'hFFFF_FFFF+1 = 0.
- Wait counter: clears on entering FETCH and increments each FETCH cycle without ack. It saturates at TIMEOUT, and o_imem_timeout sets when it reaches TIMEOUT. On timeout the request stays asserted; only rst clears the flag.
- i_redirect in BOOT is ignored.

## Timing
- First request: cycle 1 after reset is released; cycle 0 is BOOT.
- Zero-wait memory (ack same cycle as req): o_inst_valid rises 1 cycle after req. Peak throughput is 1 instruction per 2 cycles.
- Redirect accepted in DELIV at cycle t: o_pc=target and req=1 at t+1; earliest valid at t+2.
- Redirect in FETCH while waiting: the old request completes at ack cycle a; target request issues at a+1.
- All outputs are registered except o_imem_req and o_inst_valid, which decode from state.

## Structure
- Shared header: state encodings (BOOT=2'd0, FETCH=2'd1, DELIV=2'd2), RESET_PC default, counter width derived from TIMEOUT.
- One sub-module: the +1 adder reuses the existing single_pc_plus_4 instance on pc; the redirect/increment mux stays in the sequencer.

## Test plan
- Reset, then zero-wait memory with ready held high: o_pc sequence 0,1,2,3; o_inst_valid pulses every 2nd cycle; o_inst_pc matches.
- ack delayed 3 cycles at pc=5: o_pc stays 5 with req=1 for 4 cycles; no valid until after ack; no timeout with TIMEOUT=16.
- Redirect to 32'h40 in FETCH during a wait at pc=7: ack data for 7 is never delivered; next request is at 32'h40.
- Redirect to 32'h80 in DELIV with ready=0: valid drops next cycle, o_pc=32'h80. Repeat with ready=1: the instruction counts as accepted and o_pc=32'h80.
- RESET_PC=32'hFFFF_FFFF, ready=1: fetches FFFF_FFFF, then 0.
- Never ack with TIMEOUT=4: o_imem_timeout rises after 4 unacked FETCH cycles and stays high. Assert rst mid-wait: all outputs return to reset values, then BOOT, then FETCH at RESET_PC.

Source files
------------

// File: rtl/single_pc_sequencer_pkg.sv
// rtl/single_pc_sequencer_pkg.sv - shared encodings and defaults for the PC sequencer
package single_pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DELIV = 2'd2
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_TIMEOUT  = 16;

    // Wide enough to hold TIMEOUT itself, since the counter saturates there.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/single_pc_sequencer_if.sv
// rtl/single_pc_sequencer_if.sv - instruction memory and decode handshake bundle
interface single_pc_sequencer_if;
    logic [31:0] o_pc;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;

    modport master (
        output o_pc, o_imem_req, o_inst, o_inst_pc, o_inst_valid,
        input  i_imem_ack, i_imem_data, i_inst_ready
    );

    modport slave (
        input  o_pc, o_imem_req, o_inst, o_inst_pc, o_inst_valid,
        output i_imem_ack, i_imem_data, i_inst_ready
    );
endinterface

// File: rtl/single_pc_plus_4.sv
// rtl/single_pc_plus_4.sv - next sequential PC; the PC is word-addressed so the step is one
module single_pc_plus_4 (
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_next
);
    assign o_pc_next = i_pc + 32'd1;
endmodule

// File: rtl/single_pc_sequencer.sv
// rtl/single_pc_sequencer.sv - program counter owner and single-outstanding fetch sequencer
module single_pc_sequencer
    import single_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    single_pc_sequencer_if.master bus,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_imem_timeout
);
    localparam int               CNT_W   = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    seq_state_t       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pending;
    logic             r_kill;
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_pc;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    seq_state_t       w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_pending_nxt;
    logic             w_kill_nxt;
    logic [31:0]      w_inst_nxt;
    logic [31:0]      w_inst_pc_nxt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_timeout_nxt;
    logic             w_req;
    logic             w_valid;
    logic [31:0]      w_pc_plus1;

    single_pc_plus_4 u_pc_inc (
        .i_pc      (r_pc),
        .o_pc_next (w_pc_plus1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pending  <= '0;
            r_kill     <= 1'b0;
            r_inst     <= '0;
            r_inst_pc  <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pending  <= w_pending_nxt;
            r_kill     <= w_kill_nxt;
            r_inst     <= w_inst_nxt;
            r_inst_pc  <= w_inst_pc_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pending_nxt  = r_pending;
        w_kill_nxt     = r_kill;
        w_inst_nxt     = r_inst;
        w_inst_pc_nxt  = r_inst_pc;
        w_wait_cnt_nxt = r_wait_cnt;
        w_req          = 1'b0;
        w_valid        = 1'b0;

        case (r_state)
            BOOT: begin
                w_state_nxt    = FETCH;
                w_wait_cnt_nxt = '0;
            end
            FETCH: begin
                w_req = 1'b1;
                if (bus.i_imem_ack) begin
                    w_wait_cnt_nxt = '0;
                    w_kill_nxt     = 1'b0;
                    // A redirect landing on the ack cycle beats any older pending target.
                    if (i_redirect) begin
                        w_pc_nxt = i_redirect_pc;
                    end else if (r_kill) begin
                        w_pc_nxt = r_pending;
                    end else begin
                        w_inst_nxt    = bus.i_imem_data;
                        w_inst_pc_nxt = r_pc;
                        w_state_nxt   = DELIV;
                    end
                end else begin
                    if (i_redirect) begin
                        w_kill_nxt    = 1'b1;
                        w_pending_nxt = i_redirect_pc;
                    end
                    if (r_wait_cnt != CNT_MAX) begin
                        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                    end
                end
            end
            DELIV: begin
                w_valid = 1'b1;
                if (i_redirect) begin
                    w_pc_nxt       = i_redirect_pc;
                    w_state_nxt    = FETCH;
                    w_wait_cnt_nxt = '0;
                end else if (bus.i_inst_ready) begin
                    w_pc_nxt       = w_pc_plus1;
                    w_state_nxt    = FETCH;
                    w_wait_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        w_timeout_nxt = r_timeout | (w_wait_cnt_nxt == CNT_MAX);
    end

    assign bus.o_pc         = r_pc;
    assign bus.o_imem_req   = w_req;
    assign bus.o_inst       = r_inst;
    assign bus.o_inst_pc    = r_inst_pc;
    assign bus.o_inst_valid = w_valid;
    assign o_imem_timeout   = r_timeout;

endmodule
